riscv_hwloop_cfg_seq: RTL
=========================

# riscv_hwloop_cfg_seq

Hardware-loop configuration sequencer and register bank. Accepts loop-setup commands from the ID stage over a valid/ready handshake and holds per-loop start, end and counter registers. Those registers feed the hardware-loop end-address comparator. The block applies the comparator's decrement requests, and it stalls any write to a loop that still has decrements in flight in the pipeline, bounded by a timeout.

## Interface
- N_REGS, 2, number of hardware loops
- IDX_W, 1, loop index width; must equal $clog2(N_REGS), minimum 1
- MAX_WAIT, 8, maximum WAIT cycles before a stalled write is forced
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted this cycle when high together with cmd_valid_i
- cmd_op_i  in  2  00 START, 01 END, 10 COUNT, 11 SETUP (writes all three)
- cmd_idx_i  in  IDX_W  target loop
- cmd_start_i  in  32  start address
- cmd_end_i  in  32  end address
- cmd_cnt_i  in  32  iteration count
- hwlp_dec_cnt_i  in  N_REGS  decrement request from the comparator, one-hot
- hwlp_dec_pend_i  in  N_REGS  decrement for loop k in flight, not yet retired
- hwlp_start_addr_o  out  N_REGS x 32  start registers
- hwlp_end_addr_o  out  N_REGS x 32  end registers
- hwlp_counter_o  out  N_REGS x 32  counter registers
- hwlp_active_o  out  N_REGS  counter[k] != 0
- timeout_o  out  1  one-cycle pulse when a write is forced by the timeout

## Operation
- Reset values:
  - All start, end and counter registers are 0.
  - hwlp_active_o = 0 and timeout_o = 0.
  - FSM is in IDLE and the wait counter is 0.
  - cmd_ready_o = 0 while rst is high.
- FSM has two states, IDLE and WAIT. conflict = hwlp_dec_pend_i[cmd_idx_i].
  - IDLE, valid and no conflict: cmd_ready_o = 1 (combinational). Write occurs and the FSM stays in IDLE.
  - IDLE, valid and conflict: cmd_ready_o = 0. FSM moves to WAIT and the wait counter is cleared.
  - WAIT, no conflict: cmd_ready_o = 1, write occurs, FSM returns to IDLE.
  - WAIT, conflict and wait counter = MAX_WAIT-1: cmd_ready_o = 1, write occurs, timeout_o pulses, FSM returns to IDLE.
  - WAIT otherwise: the wait counter increments.
  - WAIT with cmd_valid_i dropped (protocol violation): FSM returns to IDLE and nothing is written.
- Requester rule: while valid is high and ready is low, op, idx and data are held stable.
- Writes:
  - START writes start[idx] and END writes end[idx]. Bit 0 of both is forced to 0.
  - COUNT writes counter[idx].
  - SETUP writes all three registers.
  - idx >= N_REGS: the command is accepted (handshake completes) and nothing is written.
- Decrement: when hwlp_dec_cnt_i[k] is high and counter[k] != 0, counter[k] <= counter[k]-1. When counter[k] = 0 the request is ignored, so the counter never wraps.
- Simultaneous events on the same loop k:
  - COUNT or SETUP write plus a decrement: the write wins and the decrement is dropped.
  - START or END write plus a decrement: both take effect.
- Decrements to other loops are unaffected by a stalled or executing command.

## Timing
- Accepted write: visible on the outputs the cycle after the handshake.
- Decrement: visible on the outputs the cycle after hwlp_dec_cnt_i.
- hwlp_active_o is registered-equivalent, derived directly from the counter registers.
- Conflict-free command: zero stall cycles. Stalled command: at most MAX_WAIT cycles in WAIT.
- Reset asserted mid-WAIT: the FSM returns to IDLE immediately, all registers clear, and the pending command is dropped.
- timeout_o is high for exactly the handshake cycle of a forced write.

## Structure
- Package riscv_hwloop_pkg holds:
  - the hwlp_op_e enum (START, END, COUNT, SETUP);
  - the cfg_state_e enum (IDLE, WAIT).
- Sub-module riscv_hwloop_reg_slot implements one loop's start/end/counter registers with the write-versus-decrement priority. It is instantiated N_REGS times.
- The top level contains the FSM, the wait counter, handshake generation and index decode.

## Test plan
- Reset, then SETUP idx0 with start=0x100, end=0x120, cnt=3, no pending decrement -> ready the same cycle; next cycle outputs read 0x100/0x120/3 and active[0]=1.
- counter0=2, dec_cnt=01 for three consecutive cycles -> counter reads 1, then 0, then stays 0; active[0] falls after the second decrement.
- COUNT idx1 with cnt=5 while dec_pend=10 for 3 cycles -> ready rises on the 4th cycle, no timeout pulse, counter1=5 the next cycle.
- dec_pend=01 held permanently, COUNT idx0 with cnt=7, MAX_WAIT=8 -> 8 WAIT cycles, then ready=1 with timeout_o=1, counter0=7.
- Same cycle: COUNT idx0 cnt=9 and dec_cnt=01 with counter0=4 -> counter0=9. Repeat with a START write instead -> start updated and counter0=3.
- Reset asserted during WAIT -> cmd_ready_o=0, all registers read 0, FSM in IDLE after release.

Source files
------------

// File: rtl/riscv_hwloop_pkg.sv
// Shared types for the hardware-loop configuration sequencer.
package riscv_hwloop_pkg;

   typedef enum logic [1:0] {
      HWLP_START = 2'b00,
      HWLP_END   = 2'b01,
      HWLP_COUNT = 2'b10,
      HWLP_SETUP = 2'b11
   } hwlp_op_e;

   typedef enum logic {
      CFG_IDLE = 1'b0,
      CFG_WAIT = 1'b1
   } cfg_state_e;

endpackage

// File: rtl/riscv_hwloop_cfg_seq_if.sv
// Command handshake, comparator decrement inputs and loop register outputs.
interface riscv_hwloop_cfg_seq_if
   import riscv_hwloop_pkg::*;
#(
   parameter int N_REGS = 2,
   parameter int IDX_W  = 1
);
   logic                         cmd_valid_i;
   logic                         cmd_ready_o;
   hwlp_op_e                     cmd_op_i;
   logic [IDX_W-1:0]             cmd_idx_i;
   logic [31:0]                  cmd_start_i;
   logic [31:0]                  cmd_end_i;
   logic [31:0]                  cmd_cnt_i;
   logic [N_REGS-1:0]            hwlp_dec_cnt_i;
   logic [N_REGS-1:0]            hwlp_dec_pend_i;
   logic [N_REGS-1:0][31:0]      hwlp_start_addr_o;
   logic [N_REGS-1:0][31:0]      hwlp_end_addr_o;
   logic [N_REGS-1:0][31:0]      hwlp_counter_o;
   logic [N_REGS-1:0]            hwlp_active_o;
   logic                         timeout_o;

   modport master (
      output cmd_valid_i, cmd_op_i, cmd_idx_i, cmd_start_i, cmd_end_i, cmd_cnt_i,
             hwlp_dec_cnt_i, hwlp_dec_pend_i,
      input  cmd_ready_o, hwlp_start_addr_o, hwlp_end_addr_o, hwlp_counter_o,
             hwlp_active_o, timeout_o
   );

   modport slave (
      input  cmd_valid_i, cmd_op_i, cmd_idx_i, cmd_start_i, cmd_end_i, cmd_cnt_i,
             hwlp_dec_cnt_i, hwlp_dec_pend_i,
      output cmd_ready_o, hwlp_start_addr_o, hwlp_end_addr_o, hwlp_counter_o,
             hwlp_active_o, timeout_o
   );
endinterface

// File: rtl/riscv_hwloop_reg_slot.sv
// One hardware loop's start/end/counter registers. A counter write beats a
// same-cycle decrement; start/end writes leave the decrement intact.
module riscv_hwloop_reg_slot
   import riscv_hwloop_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en_i,
   input  hwlp_op_e    op_i,
   input  logic [31:0] start_i,
   input  logic [31:0] end_i,
   input  logic [31:0] cnt_i,
   input  logic        dec_i,
   output logic [31:0] start_o,
   output logic [31:0] end_o,
   output logic [31:0] cnt_o,
   output logic        active_o
);
   logic [31:0] start_q, start_d;
   logic [31:0] end_q, end_d;
   logic [31:0] cnt_q, cnt_d;

   // Next register values: decrement first, then let a write override.
   always_comb begin
      start_d = start_q;
      end_d   = end_q;
      cnt_d   = cnt_q;
      if (dec_i && (cnt_q != 32'd0)) cnt_d = cnt_q - 32'd1;
      if (wr_en_i) begin
         case (op_i)
            HWLP_START: start_d = {start_i[31:1], 1'b0};
            HWLP_END:   end_d   = {end_i[31:1], 1'b0};
            HWLP_COUNT: cnt_d   = cnt_i;
            HWLP_SETUP: begin
               start_d = {start_i[31:1], 1'b0};
               end_d   = {end_i[31:1], 1'b0};
               cnt_d   = cnt_i;
            end
            default: ;
         endcase
      end
   end

   // Register state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_q <= 32'd0;
         end_q   <= 32'd0;
         cnt_q   <= 32'd0;
      end else begin
         start_q <= start_d;
         end_q   <= end_d;
         cnt_q   <= cnt_d;
      end
   end

   assign start_o  = start_q;
   assign end_o    = end_q;
   assign cnt_o    = cnt_q;
   assign active_o = (cnt_q != 32'd0);
endmodule

// File: rtl/riscv_hwloop_cfg_seq.sv
// Hardware-loop configuration sequencer: accepts loop-setup commands, stalls
// writes to loops with decrements still in flight (bounded), owns the slots.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// CFG_IDLE | no stalled command; conflict-free commands accepted at once
// CFG_WAIT | command stalled on pending decrement; wait counter running
module riscv_hwloop_cfg_seq
   import riscv_hwloop_pkg::*;
#(
   parameter int N_REGS   = 2,
   parameter int IDX_W    = 1,
   parameter int MAX_WAIT = 8
)(
   input logic                    clk,
   input logic                    rst,
   riscv_hwloop_cfg_seq_if.slave  bus
);
   localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

   cfg_state_e        state_q, state_d;
   logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic              conflict;
   logic [N_REGS-1:0] idx_sel;
   logic              ready;
   logic              timeout;
   logic              hs;

   logic [31:0] start_w [N_REGS];
   logic [31:0] end_w   [N_REGS];
   logic [31:0] cnt_w   [N_REGS];
   logic [N_REGS-1:0] active_w;

   // Index decode; out-of-range indices select nothing and never conflict.
   always_comb begin
      conflict = 1'b0;
      idx_sel  = '0;
      for (int k = 0; k < N_REGS; k++) begin
         if (bus.cmd_idx_i == IDX_W'(k)) begin
            idx_sel[k] = 1'b1;
            conflict   = bus.hwlp_dec_pend_i[k];
         end
      end
   end

   // Next-state, wait counter and handshake generation.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      ready      = 1'b0;
      timeout    = 1'b0;
      case (state_q)
         CFG_IDLE: begin
            if (bus.cmd_valid_i) begin
               if (!conflict) begin
                  ready = 1'b1;
               end else begin
                  state_d    = CFG_WAIT;
                  wait_cnt_d = '0;
               end
            end
         end
         CFG_WAIT: begin
            if (!bus.cmd_valid_i) begin
               state_d = CFG_IDLE;
            end else if (!conflict) begin
               ready   = 1'b1;
               state_d = CFG_IDLE;
            end else if (wait_cnt_q == WAIT_LAST) begin
               ready   = 1'b1;
               timeout = 1'b1;
               state_d = CFG_IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         default: state_d = CFG_IDLE;
      endcase
      if (rst) begin
         ready   = 1'b0;
         timeout = 1'b0;
      end
   end

   // FSM state and wait counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= CFG_IDLE;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   assign hs              = bus.cmd_valid_i & ready;
   assign bus.cmd_ready_o = ready;
   assign bus.timeout_o   = timeout;

   for (genvar k = 0; k < N_REGS; k++) begin : g_slot
      riscv_hwloop_reg_slot u_slot (
         .clk      (clk),
         .rst      (rst),
         .wr_en_i  (hs & idx_sel[k]),
         .op_i     (bus.cmd_op_i),
         .start_i  (bus.cmd_start_i),
         .end_i    (bus.cmd_end_i),
         .cnt_i    (bus.cmd_cnt_i),
         .dec_i    (bus.hwlp_dec_cnt_i[k]),
         .start_o  (start_w[k]),
         .end_o    (end_w[k]),
         .cnt_o    (cnt_w[k]),
         .active_o (active_w[k])
      );
   end

   // Pack slot outputs onto the bus.
   always_comb begin
      bus.hwlp_start_addr_o = '0;
      bus.hwlp_end_addr_o   = '0;
      bus.hwlp_counter_o    = '0;
      for (int k = 0; k < N_REGS; k++) begin
         bus.hwlp_start_addr_o[k] = start_w[k];
         bus.hwlp_end_addr_o[k]   = end_w[k];
         bus.hwlp_counter_o[k]    = cnt_w[k];
      end
   end

   assign bus.hwlp_active_o = active_w;
endmodule
